// File: rtl/demux_stream_scheduler.sv
// -----------------------------------------------------------------------------
// demux_stream_scheduler
//
// Sequencing controller in front of the demultiplexer datapath. Accepts one
// valid/ready input stream, holds at most one word, and steers it to exactly
// one of OUT_OUTPUTS valid/ready output channels. The target channel is taken
// from a rotating round-robin pointer (mode = 0) or from the per-word
// destination index (mode = 1). Addressed words whose destination does not
// exist are consumed and counted instead of being buffered.
//
// Ports:
//   clk         - single clock, all state on the rising edge
//   rst         - synchronous, active-high reset
//   mode        - 0 = round-robin, 1 = addressed; sampled on acceptance only
//   in_data     - input word
//   in_dest     - destination index (addressed mode)
//   in_valid    - input word present
//   in_ready    - scheduler can take a word this cycle
//   outs        - per-channel data, zero on every channel not being driven
//   out_valid   - per-channel valid, one-hot or zero
//   out_ready   - per-channel ready
//   cur_sel     - target of the held word, 0 when empty
//   rr_ptr      - next round-robin target
//   drop_pulse  - one-cycle pulse after an out-of-range word was discarded
//   drop_count  - saturating count of discarded words
// -----------------------------------------------------------------------------
module demux_stream_scheduler #(
    parameter int OUT_BITWIDTH = 8,
    parameter int OUT_OUTPUTS  = 4,
    parameter int LOG2_OF_OUT  = $clog2(OUT_OUTPUTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [OUT_BITWIDTH-1:0] in_data,
    input  logic [LOG2_OF_OUT-1:0]  in_dest,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_BITWIDTH-1:0] outs [OUT_OUTPUTS],
    output logic [OUT_OUTPUTS-1:0]  out_valid,
    input  logic [OUT_OUTPUTS-1:0]  out_ready,
    output logic [LOG2_OF_OUT-1:0]  cur_sel,
    output logic [LOG2_OF_OUT-1:0]  rr_ptr,
    output logic                    drop_pulse,
    output logic [7:0]              drop_count
);

    // Number of codes the select field can express; may exceed OUT_OUTPUTS.
    localparam int NUM_SLOTS = 1 << LOG2_OF_OUT;
    localparam logic [LOG2_OF_OUT-1:0] LAST_IDX = LOG2_OF_OUT'(OUT_OUTPUTS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [OUT_BITWIDTH-1:0] data_q, data_d;
    logic [LOG2_OF_OUT-1:0]  sel_q, sel_d;
    logic [LOG2_OF_OUT-1:0]  rr_ptr_q, rr_ptr_d;
    logic                    drop_pulse_q, drop_pulse_d;
    logic [7:0]              drop_count_q, drop_count_d;

    logic [NUM_SLOTS-1:0]    ready_pad;
    logic                    dest_ok;
    logic                    target_ready;
    logic                    out_hs;
    logic                    accept;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // With a power-of-two channel count every destination code is a real
    // channel, so the range check collapses to a constant.
    generate
        if (NUM_SLOTS == OUT_OUTPUTS) begin : g_dest_full_range
            assign dest_ok = 1'b1;
        end else begin : g_dest_partial_range
            assign dest_ok = (int'(in_dest) < OUT_OUTPUTS);
        end
    endgenerate

    // Pad out_ready to the full select range so indexing by sel_q is always
    // in bounds; sel_q itself only ever holds real channel numbers.
    always_comb begin
        ready_pad                  = '0;
        ready_pad[OUT_OUTPUTS-1:0] = out_ready;
    end

    always_comb begin
        target_ready = ready_pad[sel_q];
        out_hs       = (state_q == FULL) && target_ready;
        // Pass-through: a word leaving this cycle frees the slot for a new one.
        in_ready     = (state_q == EMPTY) || out_hs;
        accept       = in_valid && in_ready;
    end

    // Next-state and holding register update
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        drop_pulse_d = 1'b0;
        drop_count_d = drop_count_q;

        if (out_hs) begin
            state_d = EMPTY;
        end

        if (accept) begin
            if (!mode) begin
                state_d  = FULL;
                data_d   = in_data;
                sel_d    = rr_ptr_q;
                rr_ptr_d = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + 1'b1;
            end else if (dest_ok) begin
                state_d = FULL;
                data_d  = in_data;
                sel_d   = in_dest;
            end else begin
                // Handshake completes, but the word is discarded.
                drop_pulse_d = 1'b1;
                drop_count_d = sat_inc8(drop_count_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            sel_q        <= '0;
            rr_ptr_q     <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    // The held word is only visible while FULL, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // Output steering
    always_comb begin
        for (int i = 0; i < OUT_OUTPUTS; i++) begin
            out_valid[i] = (state_q == FULL) && (sel_q == LOG2_OF_OUT'(i));
            outs[i]      = ((state_q == FULL) && (sel_q == LOG2_OF_OUT'(i))) ? data_q : '0;
        end
        cur_sel = (state_q == FULL) ? sel_q : '0;
    end

    assign rr_ptr     = rr_ptr_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/demux_stream_scheduler.md
# demux_stream_scheduler

Sequencing controller for the demultiplexer datapath. It accepts a single valid/ready input stream, buffers one word, and steers it to exactly one of OUT_OUTPUTS valid/ready output channels. The target is chosen either by a rotating round-robin pointer or by a per-word destination index. It sits in front of the demultiplexer and owns its `sel`, adding flow control, ordering and error accounting.

## Interface
- OUT_BITWIDTH, default 8: width of each data word.
- OUT_OUTPUTS, default 4: number of output channels, must be ≥ 2.
- LOG2_OF_OUT, default $clog2(OUT_OUTPUTS): width of select, destination and pointer fields.
- clk  input  1: single clock; all state updates on rising edge.
- rst  input  1: synchronous, active-high reset.
- mode  input  1: 0 = round-robin distribution, 1 = addressed distribution; sampled only on input acceptance.
- in_data  input  OUT_BITWIDTH: input word.
- in_dest  input  LOG2_OF_OUT: destination index, used only when mode = 1.
- in_valid  input  1: input word present.
- in_ready  output  1: scheduler can accept a word this cycle.
- outs  output  OUT_BITWIDTH × [OUT_OUTPUTS] (unpacked): per-channel data.
- out_valid  output  OUT_OUTPUTS: per-channel valid, at most one bit set (one-hot or zero).
- out_ready  input  OUT_OUTPUTS: per-channel ready.
- cur_sel  output  LOG2_OF_OUT: target index of the held word; 0 when empty.
- rr_ptr  output  LOG2_OF_OUT: next round-robin target.
- drop_pulse  output  1: one-cycle pulse when an out-of-range addressed word is discarded.
- drop_count  output  8: saturating count of discarded words.

## Operation
- State machine has two states:
  - EMPTY: no word held.
  - FULL: one word held in the holding register, with its target in `sel_q`.
- Input acceptance happens when in_valid && in_ready.
- in_ready = (state == EMPTY) || (state == FULL && out_ready[sel_q]). Pass-through is allowed, so one word per cycle is sustained while the target is ready.
- Output handshake happens when the scheduler is FULL and out_ready[sel_q] = 1.
  - out_valid[sel_q] = 1 in FULL; every other out_valid bit is 0.
  - outs[sel_q] = held word; all other outs entries are 0.
  - In EMPTY, all outs are 0 and out_valid = 0.
- Target selection at acceptance:
  - mode = 0: target = rr_ptr. rr_ptr then advances by 1 modulo OUT_OUTPUTS, wrapping from OUT_OUTPUTS-1 to 0.
  - mode = 1: target = in_dest. rr_ptr is unchanged.
  - mode = 1 with in_dest ≥ OUT_OUTPUTS: the word is accepted (handshake completes) but not buffered.
    - drop_pulse = 1 on the next cycle.
    - drop_count increments and holds at 255.
    - State follows the output handshake only: stays EMPTY, or goes FULL→EMPTY if the held word left this cycle.
- Transitions:
  - EMPTY + accept (valid target) → FULL.
  - FULL + output handshake + no accept → EMPTY.
  - FULL + output handshake + accept (valid target) → FULL with the new word and target.
  - FULL + no handshake → FULL. Word and target are held stable, and the mode input is ignored.
- A round-robin target does not skip not-ready channels. Strict ordering is preserved; a stalled channel stalls the stream.
- A mode change while FULL does not affect the held word.

## Timing
- Reset values: state = EMPTY, rr_ptr = 0, cur_sel = 0, out_valid = 0, all outs = 0, in_ready = 1, drop_pulse = 0, drop_count = 0.
- Latency: a word accepted in cycle t appears on out_valid/outs in cycle t+1. There is no combinational path from in_data to outs.
- in_ready depends combinationally on out_ready[sel_q] only; it never depends on in_valid.
- Once asserted, out_valid stays high with stable data until the handshake completes.
- drop_pulse is registered and asserted in cycle t+1 for a drop at t.
- Reset asserted mid-transfer discards the held word on the same edge; no output handshake is reported for it.

## Test plan
- Round-robin, 4 channels: reset, mode = 0, all out_ready = 1, send 0x11–0x16 back-to-back.
  - Required: channels 0,1,2,3,0,1 each receive their word one cycle after acceptance.
  - Required: in_ready stays 1 throughout; rr_ptr = 2 at the end.
- Backpressure: mode = 0, out_ready[1] = 0 for 5 cycles, send 0xA0, 0xA1.
  - Required: 0xA0 goes to channel 0.
  - Required: 0xA1 is held on channel 1 with stable data, and in_ready = 0, until out_ready[1] rises; then it transfers and in_ready returns to 1.
- Addressed mode: mode = 1, send 0x55 with dest 3, then 0x66 with dest 0.
  - Required: out_valid = 4'b1000 carrying 0x55, then 4'b0001 carrying 0x66.
  - Required: rr_ptr unchanged.
- Out-of-range drop: OUT_OUTPUTS = 3, mode = 1, send a word with dest 3, repeated 300 times.
  - Required: no out_valid ever asserts; drop_pulse fires each time; drop_count saturates at 255.
- Reset mid-operation: hold 0x77 on a stalled channel 2, assert rst for 1 cycle.
  - Required: next cycle out_valid = 0, in_ready = 1, rr_ptr = 0, drop_count = 0.
  - Required: 0x77 is never delivered.
